// File: rtl/io_bridge_pkg.sv
// Shared command/reply codes and FSM state encoding for the byte-stream SRAM bridge.
package io_bridge_pkg;

    localparam logic [7:0] CMD_WR  = 8'h57;
    localparam logic [7:0] CMD_RD  = 8'h52;
    localparam logic [7:0] RSP_ACK = 8'h4B;
    localparam logic [7:0] RSP_ERR = 8'h3F;

    typedef enum logic [2:0] {
        S_CMD   = 3'd0,
        S_ADDR1 = 3'd1,
        S_ADDR0 = 3'd2,
        S_WDATA = 3'd3,
        S_WRITE = 3'd4,
        S_RDCAP = 3'd5,
        S_TX    = 3'd6
    } state_e;

    // States in which an incoming byte may be consumed.
    function automatic logic rx_state(input state_e s);
        return (s == S_CMD) || (s == S_ADDR1) || (s == S_ADDR0) || (s == S_WDATA);
    endfunction

endpackage

// File: rtl/io_mem_bridge_if.sv
// Byte-stream rx/tx handshakes plus the SRAM port of the bridge.
interface io_mem_bridge_if #(
    parameter int unsigned ADDR_WIDTH = 8
);
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic [7:0]            tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_write;
    logic [31:0]           mem_wdata;
    logic [31:0]           mem_rdata;

    modport master (
        input  rx_data, rx_valid, tx_ready, mem_rdata,
        output rx_ready, tx_data, tx_valid, mem_addr, mem_write, mem_wdata
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, mem_rdata,
        input  rx_ready, tx_data, tx_valid, mem_addr, mem_write, mem_wdata
    );
endinterface

// File: rtl/io_tx_shifter.sv
// Serialises 1..4 bytes of a 32-bit word MSB first over a valid/ready link.
module io_tx_shifter (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_load,
    input  logic [31:0] i_data,
    input  logic [2:0]  i_count,
    input  logic        i_ready,
    output logic [7:0]  o_data,
    output logic        o_valid,
    output logic        o_done
);
    logic [31:0] sh_q;
    logic [2:0]  cnt_q;
    logic        fire;

    assign o_data  = sh_q[31:24];
    assign o_valid = (cnt_q != 3'd0);
    assign fire    = o_valid & i_ready;
    assign o_done  = fire & (cnt_q == 3'd1);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sh_q  <= '0;
            cnt_q <= '0;
        end else if (i_load) begin
            sh_q  <= i_data;
            cnt_q <= i_count;
        end else if (fire) begin
            sh_q  <= {sh_q[23:0], 8'h00};
            cnt_q <= cnt_q - 3'd1;
        end
    end

endmodule

// File: rtl/io_mem_bridge.sv
// Command parser bridging a byte stream onto an SRAM port (comb. read, sync. write).
module io_mem_bridge
    import io_bridge_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic            i_clk,
    input  logic            i_rst,
    io_mem_bridge_if.master bus,
    output logic            o_busy,
    output logic            o_err
);
    localparam int unsigned IdleW  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned TLimit = (TIMEOUT > 1) ? TIMEOUT - 1 : 1;

    state_e                state_q;
    logic                  is_wr_q;
    logic [7:0]            addr_hi_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [1:0]            byte_cnt_q;
    logic                  write_q;
    logic                  err_q;
    logic [IdleW-1:0]      idle_q;

    logic        rx_ready;
    logic        rx_fire;
    logic        cmd_ok;
    logic        counting;
    logic        idle_hit;
    logic        tx_load;
    logic [31:0] tx_load_data;
    logic [2:0]  tx_load_count;
    logic        tx_done;

    assign rx_ready = rx_state(state_q);
    assign rx_fire  = bus.rx_valid & rx_ready;
    assign cmd_ok   = (bus.rx_data == CMD_WR) || (bus.rx_data == CMD_RD);
    assign counting = (state_q == S_ADDR1) || (state_q == S_ADDR0) || (state_q == S_WDATA);
    // Abort on the edge where the idle count would reach TIMEOUT-1.
    assign idle_hit = (TIMEOUT != 0) && counting && !rx_fire &&
                      ((32'(idle_q) + 32'd1) >= TLimit);

    assign bus.rx_ready  = rx_ready;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_write = write_q;
    assign bus.mem_wdata = wdata_q;
    assign o_busy        = (state_q != S_CMD);
    assign o_err         = err_q;

    always_comb begin
        tx_load       = 1'b0;
        tx_load_data  = {RSP_ERR, 24'h0};
        tx_load_count = 3'd1;
        if (state_q == S_RDCAP) begin
            tx_load       = 1'b1;
            tx_load_data  = bus.mem_rdata;
            tx_load_count = 3'd4;
        end else if (state_q == S_WRITE) begin
            tx_load      = 1'b1;
            tx_load_data = {RSP_ACK, 24'h0};
        end else if ((state_q == S_CMD) && rx_fire && !cmd_ok) begin
            tx_load = 1'b1;
        end
    end

    io_tx_shifter u_tx (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (tx_load),
        .i_data  (tx_load_data),
        .i_count (tx_load_count),
        .i_ready (bus.tx_ready),
        .o_data  (bus.tx_data),
        .o_valid (bus.tx_valid),
        .o_done  (tx_done)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= S_CMD;
            is_wr_q    <= 1'b0;
            addr_hi_q  <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            byte_cnt_q <= '0;
            write_q    <= 1'b0;
            err_q      <= 1'b0;
            idle_q     <= '0;
        end else begin
            write_q <= 1'b0;
            err_q   <= 1'b0;

            if ((TIMEOUT == 0) || !counting || rx_fire || idle_hit) begin
                idle_q <= '0;
            end else begin
                idle_q <= idle_q + IdleW'(1);
            end

            if (idle_hit) begin
                err_q   <= 1'b1;
                state_q <= S_CMD;
            end else begin
                unique case (state_q)
                    S_CMD: begin
                        if (rx_fire) begin
                            if (cmd_ok) begin
                                is_wr_q <= (bus.rx_data == CMD_WR);
                                state_q <= S_ADDR1;
                            end else begin
                                err_q   <= 1'b1;
                                state_q <= S_TX;
                            end
                        end
                    end
                    S_ADDR1: begin
                        if (rx_fire) begin
                            addr_hi_q <= bus.rx_data;
                            state_q   <= S_ADDR0;
                        end
                    end
                    S_ADDR0: begin
                        if (rx_fire) begin
                            addr_q     <= ADDR_WIDTH'({addr_hi_q, bus.rx_data});
                            byte_cnt_q <= '0;
                            state_q    <= is_wr_q ? S_WDATA : S_RDCAP;
                        end
                    end
                    S_WDATA: begin
                        if (rx_fire) begin
                            wdata_q    <= {wdata_q[23:0], bus.rx_data};
                            byte_cnt_q <= byte_cnt_q + 2'd1;
                            if (byte_cnt_q == 2'd3) begin
                                write_q <= 1'b1;
                                state_q <= S_WRITE;
                            end
                        end
                    end
                    S_WRITE: state_q <= S_TX;
                    S_RDCAP: state_q <= S_TX;
                    S_TX: begin
                        if (tx_done) begin
                            state_q <= S_CMD;
                        end
                    end
                    default: state_q <= S_CMD;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_io_mem_bridge.sv
// Scoreboard bench for io_mem_bridge: directed frames, a monitor checks tx bytes, writes, errors.
module tb_io_mem_bridge;
    import io_bridge_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    logic err;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  exp_tx[$];
    logic [7:0]  exp_wa[$];
    logic [31:0] exp_wd[$];
    int          exp_err = 0;

    logic [31:0] mem[256];
    logic        prev_stall;
    logic [7:0]  prev_data;

    io_mem_bridge_if #(.ADDR_WIDTH(8)) bus ();

    io_mem_bridge #(
        .ADDR_WIDTH (8),
        .TIMEOUT    (16)
    ) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .bus    (bus),
        .o_busy (busy),
        .o_err  (err)
    );

    always #5 clk = ~clk;

    assign bus.mem_rdata = mem[bus.mem_addr];

    always @(posedge clk) begin
        if (bus.mem_write) mem[bus.mem_addr] <= bus.mem_wdata;
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
        mem[7]     <= 32'h12345678;
        prev_stall <= 1'b0;
        prev_data  <= 8'h00;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail_unexpected(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=event required=none", name);
    endtask

    // Monitor: pops expectations whenever the DUT presents an output event.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                check("tx_hold_valid", 32'(bus.tx_valid), 32'd1);
                check("tx_hold_data", 32'(bus.tx_data), 32'(prev_data));
            end
            prev_stall <= bus.tx_valid && !bus.tx_ready;
            prev_data  <= bus.tx_data;
            if (bus.tx_valid && bus.tx_ready) begin
                if (exp_tx.size() == 0) fail_unexpected("tx_byte_extra");
                else check("tx_byte", 32'(bus.tx_data), 32'(exp_tx.pop_front()));
            end
            if (bus.mem_write) begin
                if (exp_wa.size() == 0) begin
                    fail_unexpected("mem_write_extra");
                end else begin
                    check("mem_addr", 32'(bus.mem_addr), 32'(exp_wa.pop_front()));
                    check("mem_wdata", bus.mem_wdata, exp_wd.pop_front());
                end
            end
            if (err) begin
                if (exp_err == 0) fail_unexpected("err_extra");
                else begin
                    exp_err--;
                    checks++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        while (!bus.rx_ready && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) fail_unexpected("rx_accept_timeout");
        step();
        bus.rx_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_tx.size() != 0 || busy) && n < 500) begin
            step();
            n++;
        end
        if (n >= 500) fail_unexpected("drain_timeout");
        step();
    endtask

    task automatic expect_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) exp_tx.push_back(w[i*8 +: 8]);
    endtask

    initial begin
        int first_err;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        bus.tx_ready = 1'b1;
        repeat (2) step();
        check("rst_rx_ready", 32'(bus.rx_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
        check("rst_mem_write", 32'(bus.mem_write), 32'd0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        rst = 1'b0;
        step();

        // 1: write DEADBEEF to 0x05
        exp_wa.push_back(8'h05);
        exp_wd.push_back(32'hDEADBEEF);
        exp_tx.push_back(RSP_ACK);
        send_byte(8'h57); send_byte(8'h00); send_byte(8'h05);
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
        check("wr_strobe_cycle", 32'(bus.mem_write), 32'd1);
        check("wr_ack_not_yet", 32'(bus.tx_valid), 32'd0);
        step();
        check("wr_ack_valid", 32'(bus.tx_valid), 32'd1);
        check("wr_ack_data", 32'(bus.tx_data), 32'h4B);
        drain();

        // 2: read back 0x05
        expect_word(32'hDEADBEEF);
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h05);
        check("rd_not_yet", 32'(bus.tx_valid), 32'd0);
        step();
        check("rd_first_valid", 32'(bus.tx_valid), 32'd1);
        check("rd_first_data", 32'(bus.tx_data), 32'hDE);
        drain();

        // 3: read with tx stalled for 10 cycles
        bus.tx_ready = 1'b0;
        expect_word(32'hDEADBEEF);
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h05);
        repeat (10) step();
        check("stall_valid", 32'(bus.tx_valid), 32'd1);
        check("stall_data", 32'(bus.tx_data), 32'hDE);
        check("stall_rx_ready", 32'(bus.rx_ready), 32'd0);
        bus.tx_ready = 1'b1;
        drain();

        // 4: bad command, then a normal frame
        exp_err++;
        exp_tx.push_back(RSP_ERR);
        send_byte(8'h41);
        check("bad_err_pulse", 32'(err), 32'd1);
        check("bad_busy", 32'(busy), 32'd1);
        drain();
        check("bad_back_idle", 32'(busy), 32'd0);
        expect_word(32'hDEADBEEF);
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h05);
        drain();

        // 5: timeout mid-write
        exp_err++;
        first_err = 0;
        send_byte(8'h57); send_byte(8'h00); send_byte(8'h07); send_byte(8'hAA);
        for (int i = 1; i <= 20; i++) begin
            step();
            if (err && first_err == 0) first_err = i;
        end
        check("timeout_cycle", 32'(first_err), 32'd15);
        check("timeout_idle", 32'(busy), 32'd0);
        expect_word(32'h12345678);
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h07);
        drain();

        // 6: reset after D1 of a write
        send_byte(8'h57); send_byte(8'h00); send_byte(8'h09);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        rst = 1'b1;
        #1;
        check("mid_rst_rx_ready", 32'(bus.rx_ready), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_wdata", bus.mem_wdata, 32'd0);
        check("mid_rst_addr", 32'(bus.mem_addr), 32'd0);
        check("mid_rst_write", 32'(bus.mem_write), 32'd0);
        step();
        rst = 1'b0;
        step();
        exp_wa.push_back(8'h09);
        exp_wd.push_back(32'hCAFEBABE);
        exp_tx.push_back(RSP_ACK);
        send_byte(8'h57); send_byte(8'h00); send_byte(8'h09);
        send_byte(8'hCA); send_byte(8'hFE); send_byte(8'hBA); send_byte(8'hBE);
        drain();
        expect_word(32'hCAFEBABE);
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h09);
        drain();

        repeat (3) step();
        check("left_tx", 32'(exp_tx.size()), 32'd0);
        check("left_wr", 32'(exp_wa.size()), 32'd0);
        check("left_err", 32'(exp_err), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
